// File: rtl/cp0_vec_irq_if.sv
// Pipeline <-> CP0 bus: register read/write, interrupt request inputs and force-jump outputs.
interface cp0_vec_irq_if #(
    parameter int IRQ_N = 4
);
    logic [1:0]       oper;
    logic [4:0]       addr_r;
    logic [31:0]      data_r;
    logic [4:0]       addr_w;
    logic [31:0]      data_w;
    logic             ir_en;
    logic [IRQ_N-1:0] ir_in;
    logic [31:0]      ret_addr;
    logic             ir;
    logic [2:0]       irq_id;
    logic             jump_en;
    logic [31:0]      jump_addr;

    modport master (
        output oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        input  data_r, ir, irq_id, jump_en, jump_addr
    );

    modport slave (
        input  oper, addr_r, addr_w, data_w, ir_en, ir_in, ret_addr,
        output data_r, ir, irq_id, jump_en, jump_addr
    );
endinterface

// File: rtl/cp0_vec_irq.sv
// Coprocessor-0 with IRQ_N edge-captured interrupt lines, masking, fixed lowest-index
// priority and vectored handler entry at EHBR + id*VECTOR_STRIDE.
module cp0_vec_irq #(
    parameter int          IRQ_N         = 4,
    parameter logic [31:0] VECTOR_STRIDE = 32'h20,
    parameter logic [31:0] RESET_EHBR    = 32'h0000_0100
) (
    input logic          clk,
    input logic          rst,
    cp0_vec_irq_if.slave bus
);
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ERET  = 2'b10;
    localparam logic [4:0] A_STATUS = 5'd12;
    localparam logic [4:0] A_CAUSE  = 5'd13;
    localparam logic [4:0] A_EPC    = 5'd14;
    localparam logic [4:0] A_EHBR   = 5'd15;

    logic             r_ie;
    logic             r_exl;
    logic [IRQ_N-1:0] r_im;
    logic [IRQ_N-1:0] r_ip;
    logic [IRQ_N-1:0] r_prev;
    logic [2:0]       r_exc;
    logic [31:0]      r_epc;
    logic [31:0]      r_ehbr;
    logic [31:0]      r_data_r;

    logic [IRQ_N-1:0] w_rise;
    logic [IRQ_N-1:0] w_req;
    logic [IRQ_N-1:0] w_w1c;
    logic [IRQ_N-1:0] w_hwclr;
    logic [IRQ_N-1:0] w_ip_next;
    logic             w_store;
    logic             w_eret;
    logic             w_ir;
    logic [2:0]       w_id;
    logic [31:0]      w_rd;
    logic [31:0]      w_vec_addr;
    logic             w_unused;

    assign w_rise  = bus.ir_in & ~r_prev;
    assign w_req   = r_ip & r_im;
    assign w_store = (bus.oper == OP_STORE);
    assign w_eret  = (bus.oper == OP_ERET) & ~rst;
    assign w_ir    = bus.ir_en & r_ie & ~r_exl & (|w_req) & (bus.oper != OP_ERET) & ~rst;

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        w_id = 3'd0;
        for (int i = IRQ_N - 1; i >= 0; i--) begin
            if (w_req[i]) w_id = 3'(i);
        end
    end

    // A new rising edge wins over both the software W1C and the hardware acknowledge.
    always_comb begin
        w_hwclr = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            w_hwclr[i] = w_ir && (w_id == 3'(i));
        end
    end

    assign w_w1c      = (w_store && bus.addr_w == A_CAUSE) ? bus.data_w[8 +: IRQ_N] : '0;
    assign w_ip_next  = (r_ip & ~w_w1c & ~w_hwclr) | w_rise;
    assign w_vec_addr = r_ehbr + 32'(w_id) * VECTOR_STRIDE;

    always_comb begin
        w_rd = 32'd0;
        case (bus.addr_r)
            A_STATUS: begin
                w_rd[0]          = r_ie;
                w_rd[1]          = r_exl;
                w_rd[8 +: IRQ_N] = r_im;
            end
            A_CAUSE: begin
                w_rd[8 +: IRQ_N] = r_ip;
                w_rd[4:2]        = r_exc;
            end
            A_EPC:   w_rd = r_epc;
            A_EHBR:  w_rd = r_ehbr;
            default: w_rd = 32'd0;
        endcase
    end

    assign bus.ir        = w_ir;
    assign bus.irq_id    = w_ir ? w_id : 3'd0;
    assign bus.jump_en   = w_ir | w_eret;
    assign bus.jump_addr = w_ir ? w_vec_addr : (w_eret ? r_epc : 32'd0);
    assign bus.data_r    = r_data_r;

    // Later assignments override earlier ones: store, then ERET, then interrupt entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie     <= 1'b0;
            r_exl    <= 1'b0;
            r_im     <= '0;
            r_ip     <= '0;
            r_prev   <= '0;
            r_exc    <= 3'd0;
            r_epc    <= 32'd0;
            r_ehbr   <= RESET_EHBR;
            r_data_r <= 32'd0;
        end else begin
            r_prev   <= bus.ir_in;
            r_data_r <= w_rd;
            r_ip     <= w_ip_next;
            if (w_store) begin
                case (bus.addr_w)
                    A_STATUS: begin
                        r_ie  <= bus.data_w[0];
                        r_exl <= bus.data_w[1];
                        r_im  <= bus.data_w[8 +: IRQ_N];
                    end
                    A_EPC:   r_epc  <= bus.data_w;
                    A_EHBR:  r_ehbr <= bus.data_w;
                    default: ;
                endcase
            end
            if (w_eret) r_exl <= 1'b0;
            if (w_ir) begin
                r_epc <= bus.ret_addr;
                r_exl <= 1'b1;
                r_exc <= w_id;
            end
        end
    end

    assign w_unused = ^{bus.data_w[31:8+IRQ_N], bus.data_w[7:2]};
endmodule
